// File: rtl/rect_render.sv
// Rectangle renderer on a VGA-style raster: sync/DE timing plus a single
// filled rectangle. Define RECT_BORDER_EN to draw a 1-pixel outline instead.
module rect_render #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic [11:0] i_x1,
    input  logic [11:0] i_x2,
    input  logic [11:0] i_y1,
    input  logic [11:0] i_y2,
    input  logic [11:0] i_fg,
    input  logic [11:0] i_bg,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_rgb,
    output logic        o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
    localparam logic [11:0] V_VIS_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] x1_s;
    logic [11:0] x2_s;
    logic [11:0] y1_s;
    logic [11:0] y2_s;

    logic        h_wrap;
    logic        v_wrap;
    logic        latch_edges;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;
    logic        in_x;
    logic        in_y;
    logic        fg_sel;
    logic [11:0] rgb_c;
`ifdef RECT_BORDER_EN
    logic        on_edge;
`endif

    // Everything below is decoded from the current (pre-increment) counters.
    always_comb begin
        h_wrap      = (h_cnt == H_LAST);
        v_wrap      = (v_cnt == V_LAST);
        latch_edges = h_wrap && (v_cnt == V_VIS_LAST);

        de_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_c = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_c = !((v_cnt >= VS_START) && (v_cnt < VS_END));

        // Inverted edges (x1 > x2 or y1 > y2) make these false: empty rectangle.
        in_x = (h_cnt >= x1_s) && (h_cnt <= x2_s);
        in_y = (v_cnt >= y1_s) && (v_cnt <= y2_s);

`ifdef RECT_BORDER_EN
        on_edge = (h_cnt == x1_s) || (h_cnt == x2_s) ||
                  (v_cnt == y1_s) || (v_cnt == y2_s);
        fg_sel  = in_x && in_y && on_edge;
`else
        fg_sel  = in_x && in_y;
`endif

        if (!de_c) begin
            rgb_c = '0;
        end else if (fg_sel) begin
            rgb_c = i_fg;
        end else begin
            rgb_c = i_bg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_stb) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Edges are shadowed once per frame, after the last visible pixel, so a
    // frame never shows a half-updated rectangle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            x1_s <= 12'hFFF;
            x2_s <= 12'h000;
            y1_s <= 12'hFFF;
            y2_s <= 12'h000;
        end else if (i_pix_stb && latch_edges) begin
            x1_s <= i_x1;
            x2_s <= i_x2;
            y1_s <= i_y1;
            y2_s <= i_y2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_hs        <= 1'b1;
            o_vs        <= 1'b1;
            o_de        <= 1'b0;
            o_rgb       <= '0;
            o_frame_end <= 1'b0;
        end else begin
            // Pulse lasts one i_clk even when strobes are sparse.
            o_frame_end <= i_pix_stb && latch_edges;
            if (i_pix_stb) begin
                o_hs  <= hs_c;
                o_vs  <= vs_c;
                o_de  <= de_c;
                o_rgb <= rgb_c;
            end
        end
    end

endmodule

// File: doc/rect_render.md
RECT_RENDER -- requirements
Module: rect_render

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port i_clk  in  1  single clock for all logic.
REQ-010 SHALL have port i_rst  in  1  reset, asynchronous, active-low.
REQ-011 SHALL have port i_pix_stb  in  1  pixel strobe; all state advances only when high.
REQ-012 SHALL have ports i_x1, i_x2, i_y1, i_y2  in  12 each  rectangle left, right, top, bottom edges (inclusive).
REQ-013 SHALL have ports i_fg, i_bg  in  12 each  RGB444 rectangle and background colours.
REQ-014 SHALL have ports o_hs, o_vs  out  1 each  horizontal/vertical sync, active-low.
REQ-015 SHALL have port o_de  out  1  data enable, high in active area.
REQ-016 SHALL have port o_rgb  out  12  pixel colour; 0 when o_de low.
REQ-017 SHALL have port o_frame_end  out  1  one-clock pulse at end of last active line.

Function
REQ-018 SHALL keep h_cnt (0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and v_cnt (0..V_TOTAL-1, likewise), both 12-bit.
REQ-019 SHALL, on i_pix_stb, increment h_cnt; at H_TOTAL-1 wrap h_cnt to 0 and increment v_cnt; at v_cnt=V_TOTAL-1 with wrap, wrap v_cnt to 0.
REQ-020 SHALL hold all counters and outputs when i_pix_stb low.
REQ-021 SHALL register outputs on i_pix_stb from pre-increment counters: one-strobe latency from count to o_hs/o_vs/o_de/o_rgb.
REQ-022 SHALL drive o_hs low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; o_vs low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-023 SHALL drive o_de high iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-024 SHALL drive o_rgb = i_fg when o_de and x1_s <= h_cnt <= x2_s and y1_s <= v_cnt <= y2_s (unsigned 12-bit), else i_bg when o_de, else 0.
REQ-025 SHALL treat x1_s > x2_s or y1_s > y2_s as empty rectangle (background only); edges beyond active area clip naturally.
REQ-026 SHALL latch i_x1/i_x2/i_y1/i_y2 into shadow x1_s/x2_s/y1_s/y2_s on the strobe where h_cnt=H_TOTAL-1 and v_cnt=V_ACTIVE-1; edge changes never tear mid-frame.
REQ-027 SHALL pulse o_frame_end high for exactly one i_clk on that same strobe edge.
REQ-028 SHALL sample i_fg/i_bg every strobe (not shadowed).

Reset
REQ-029 SHALL, while i_rst low, asynchronously force h_cnt=0, v_cnt=0, o_hs=1, o_vs=1, o_de=0, o_rgb=0, o_frame_end=0.
REQ-030 SHALL reset shadow edges to x1_s=y1_s=12'hFFF, x2_s=y2_s=0 (empty until first latch).
REQ-031 SHALL, on reset mid-frame, restart at h_cnt=0, v_cnt=0 on first strobe after release.

Configuration
REQ-032 SHALL, with macro RECT_BORDER_EN defined, use i_fg only for inside pixels where h_cnt equals x1_s or x2_s, or v_cnt equals y1_s or y2_s (1-pixel outline); interior shows i_bg.
REQ-033 SHALL, without RECT_BORDER_EN, fill the whole inclusive rectangle with i_fg.

Verification
REQ-034 Reset release, i_pix_stb constant high, 800x525 strobes -> hsync low for 96 strobes starting count 656, vsync low lines 490-491, 640x480 o_de-high pixels per frame.
REQ-035 i_x1=320,i_x2=419,i_y1=240,i_y2=314 before first latch -> frame 1 all i_bg; frame 2 exactly 100x75 pixels of i_fg at (320..419,240..314).
REQ-036 Edges changed mid-frame at line 100 -> current frame unchanged; new edges visible only from next frame; o_frame_end one pulse per frame after (799,479).
REQ-037 i_x1=500,i_x2=400 -> zero i_fg pixels; i_x2=700 with i_x1=600 -> fg clipped to 600..639.
REQ-038 i_pix_stb toggling 1-in-4, reset asserted at (h,v)=(300,200) -> outputs forced reset values immediately; first strobe after release yields count (0,0).
REQ-039 RECT_BORDER_EN defined, rectangle 10..19 x 10..19 -> exactly 36 i_fg pixels per frame.
